hopfield_learn_sequencer: RTL and testbench

//   Sequences hopfield_network through training and recall. Holds up to NUM_PATTERNS 4-bit patterns,

---
 rtl/hopfield_learn_sequencer_if.sv | 48 ++++
 rtl/hopfield_learn_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_hopfield_learn_sequencer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/hopfield_learn_sequencer_if.sv
// Purpose: bundles the pattern-store, command, recall and network-facing
//   signals of hopfield_learn_sequencer into one interface.
// Signals:
//   pat_wr_en/pat_wr_addr/pat_wr_data  pattern slot write
//   pat_clr                            clear all slot valid bits
//   train_start/recall_start/probe     commands and the recall cue
//   spikes                             spike vector from hopfield_network
//   learning_enable/pattern_input      drive into hopfield_network
//   busy/train_done/result_valid       status and completion pulses
//   result/converged/match_hit/match_idx  recall outcome, held
// Modports: slave = sequencer side, master = controller/bench side.
interface hopfield_learn_sequencer_if #(
  parameter int NUM_PATTERNS = 4
);
  localparam int PW = $clog2(NUM_PATTERNS);

  logic          pat_wr_en;
  logic [PW-1:0] pat_wr_addr;
  logic [3:0]    pat_wr_data;
  logic          pat_clr;
  logic          train_start;
  logic          recall_start;
  logic [3:0]    probe;
  logic [6:0]    spikes;
  logic          learning_enable;
  logic [3:0]    pattern_input;
  logic          busy;
  logic          train_done;
  logic          result_valid;
  logic [3:0]    result;
  logic          converged;
  logic          match_hit;
  logic [PW-1:0] match_idx;

  modport slave (
    input  pat_wr_en, pat_wr_addr, pat_wr_data, pat_clr,
           train_start, recall_start, probe, spikes,
    output learning_enable, pattern_input, busy, train_done,
           result_valid, result, converged, match_hit, match_idx
  );

  modport master (
    output pat_wr_en, pat_wr_addr, pat_wr_data, pat_clr,
           train_start, recall_start, probe, spikes,
    input  learning_enable, pattern_input, busy, train_done,
           result_valid, result, converged, match_hit, match_idx
  );
endinterface

// File: rtl/hopfield_learn_sequencer.sv
// Purpose: sequences a hopfield_network through training (each valid stored
//   pattern presented with learning_enable for LEARN_CYCLES cycles, one gap
//   cycle after each, EPOCHS passes) and through probe recalls that end on
//   settled spikes[3:0] or on a timeout.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; returns to IDLE and invalidates slots
//   bus    hopfield_learn_sequencer_if.slave (see interface header)
module hopfield_learn_sequencer #(
  parameter int NUM_PATTERNS  = 4,
  parameter int LEARN_CYCLES  = 8,
  parameter int EPOCHS        = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int MAX_RECALL    = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  hopfield_learn_sequencer_if.slave  bus
);
  localparam int PW = $clog2(NUM_PATTERNS);
  localparam int LW = $clog2(LEARN_CYCLES + 1);
  localparam int EW = $clog2(EPOCHS + 1);
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int RW = $clog2(MAX_RECALL);

  typedef enum logic [1:0] {S_IDLE, S_TRAIN, S_GAP, S_RECALL} state_t;

  state_t                  r_state, w_state_nx;
  logic [3:0]              r_pat [NUM_PATTERNS];
  logic [NUM_PATTERNS-1:0] r_valid, w_valid_nx;
  logic [PW-1:0]           r_slot, w_slot_nx;
  logic [LW-1:0]           r_lcnt, w_lcnt_nx;
  logic [EW-1:0]           r_epoch, w_epoch_nx;
  logic [SW-1:0]           r_stable, w_stable_nx, w_stable_calc;
  logic [RW-1:0]           r_rcnt, w_rcnt_nx;
  logic [3:0]              r_prev, w_prev_nx;
  logic [3:0]              r_probe, w_probe_nx;
  logic                    r_le, w_le_nx;
  logic [3:0]              r_pi, w_pi_nx;
  logic                    r_busy, w_busy_nx;
  logic                    r_td, w_td_nx;
  logic                    r_rv, w_rv_nx;
  logic [3:0]              r_result, w_result_nx;
  logic                    r_conv, w_conv_nx;
  logic                    r_hit, w_hit_nx;
  logic [PW-1:0]           r_midx, w_midx_nx;
  logic [PW:0]             w_first, w_next;
  logic                    w_mhit;
  logic [PW-1:0]           w_midx;
  logic                    w_unused_spikes;

  // {found, index} of the lowest valid slot at or above 'from'
  function automatic logic [PW:0] find_valid(input logic [NUM_PATTERNS-1:0] v,
                                             input int from);
    logic [PW:0] res;
    res = '0;
    for (int i = NUM_PATTERNS - 1; i >= 0; i--)
      if (v[i] && (i >= from)) res = {1'b1, PW'(i)};
    return res;
  endfunction

  assign w_first = find_valid(r_valid, 0);
  assign w_next  = find_valid(r_valid, int'(r_slot) + 1);
  assign w_unused_spikes = ^bus.spikes[6:4];

  // Lowest valid slot equal to the current spike sample
  always_comb begin
    w_mhit = 1'b0;
    w_midx = '0;
    for (int i = NUM_PATTERNS - 1; i >= 0; i--)
      if (r_valid[i] && (r_pat[i] == bus.spikes[3:0])) begin
        w_mhit = 1'b1;
        w_midx = PW'(i);
      end
  end

  assign w_stable_calc = (bus.spikes[3:0] == r_prev) ? r_stable + SW'(1) : '0;

  always_comb begin
    w_state_nx  = r_state;
    w_valid_nx  = r_valid;
    w_slot_nx   = r_slot;
    w_lcnt_nx   = r_lcnt;
    w_epoch_nx  = r_epoch;
    w_stable_nx = r_stable;
    w_rcnt_nx   = r_rcnt;
    w_prev_nx   = r_prev;
    w_probe_nx  = r_probe;
    w_le_nx     = 1'b0;
    w_pi_nx     = 4'd0;
    w_td_nx     = 1'b0;
    w_rv_nx     = 1'b0;
    w_result_nx = r_result;
    w_conv_nx   = r_conv;
    w_hit_nx    = r_hit;
    w_midx_nx   = r_midx;
    case (r_state)
      S_IDLE: begin
        // Clear first so a same-cycle write leaves just that slot valid
        if (bus.pat_clr)   w_valid_nx = '0;
        if (bus.pat_wr_en) w_valid_nx[bus.pat_wr_addr] = 1'b1;
        if (bus.train_start) begin
          if (w_first[PW]) begin
            w_state_nx = S_TRAIN;
            w_slot_nx  = w_first[PW-1:0];
            w_lcnt_nx  = LW'(1);
            w_epoch_nx = '0;
            w_le_nx    = 1'b1;
            w_pi_nx    = r_pat[w_first[PW-1:0]];
          end else begin
            w_td_nx = 1'b1;
          end
        end else if (bus.recall_start) begin
          // The entry edge takes recall sample 0 (no predecessor)
          w_state_nx  = S_RECALL;
          w_probe_nx  = bus.probe;
          w_pi_nx     = bus.probe;
          w_prev_nx   = bus.spikes[3:0];
          w_stable_nx = '0;
          w_rcnt_nx   = RW'(1);
        end
      end
      S_TRAIN: begin
        if (r_lcnt == LW'(LEARN_CYCLES)) begin
          w_state_nx = S_GAP;
        end else begin
          w_lcnt_nx = r_lcnt + LW'(1);
          w_le_nx   = 1'b1;
          w_pi_nx   = r_pi;
        end
      end
      S_GAP: begin
        if (w_next[PW]) begin
          w_state_nx = S_TRAIN;
          w_slot_nx  = w_next[PW-1:0];
          w_lcnt_nx  = LW'(1);
          w_le_nx    = 1'b1;
          w_pi_nx    = r_pat[w_next[PW-1:0]];
        end else begin
          w_epoch_nx = r_epoch + EW'(1);
          if (int'(r_epoch) + 1 < EPOCHS) begin
            w_state_nx = S_TRAIN;
            w_slot_nx  = w_first[PW-1:0];
            w_lcnt_nx  = LW'(1);
            w_le_nx    = 1'b1;
            w_pi_nx    = r_pat[w_first[PW-1:0]];
          end else begin
            w_state_nx = S_IDLE;
            w_td_nx    = 1'b1;
          end
        end
      end
      S_RECALL: begin
        w_pi_nx     = r_probe;
        w_prev_nx   = bus.spikes[3:0];
        w_stable_nx = w_stable_calc;
        w_rcnt_nx   = r_rcnt + RW'(1);
        // Convergence takes precedence over a simultaneous timeout
        if ((w_stable_calc == SW'(STABLE_CYCLES)) || (r_rcnt == RW'(MAX_RECALL - 1))) begin
          w_state_nx  = S_IDLE;
          w_pi_nx     = 4'd0;
          w_rv_nx     = 1'b1;
          w_result_nx = bus.spikes[3:0];
          w_conv_nx   = (w_stable_calc == SW'(STABLE_CYCLES));
          w_hit_nx    = w_mhit;
          w_midx_nx   = w_midx;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
    w_busy_nx = (w_state_nx != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_valid  <= '0;
      r_slot   <= '0;
      r_lcnt   <= '0;
      r_epoch  <= '0;
      r_stable <= '0;
      r_rcnt   <= '0;
      r_prev   <= '0;
      r_probe  <= '0;
      r_le     <= 1'b0;
      r_pi     <= '0;
      r_busy   <= 1'b0;
      r_td     <= 1'b0;
      r_rv     <= 1'b0;
      r_result <= '0;
      r_conv   <= 1'b0;
      r_hit    <= 1'b0;
      r_midx   <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_valid  <= w_valid_nx;
      r_slot   <= w_slot_nx;
      r_lcnt   <= w_lcnt_nx;
      r_epoch  <= w_epoch_nx;
      r_stable <= w_stable_nx;
      r_rcnt   <= w_rcnt_nx;
      r_prev   <= w_prev_nx;
      r_probe  <= w_probe_nx;
      r_le     <= w_le_nx;
      r_pi     <= w_pi_nx;
      r_busy   <= w_busy_nx;
      r_td     <= w_td_nx;
      r_rv     <= w_rv_nx;
      r_result <= w_result_nx;
      r_conv   <= w_conv_nx;
      r_hit    <= w_hit_nx;
      r_midx   <= w_midx_nx;
    end
  end

  // Pattern data is not reset; only the valid bits are
  always_ff @(posedge clk) begin
    if ((r_state == S_IDLE) && bus.pat_wr_en)
      r_pat[bus.pat_wr_addr] <= bus.pat_wr_data;
  end

  assign bus.learning_enable = r_le;
  assign bus.pattern_input   = r_pi;
  assign bus.busy            = r_busy;
  assign bus.train_done      = r_td;
  assign bus.result_valid    = r_rv;
  assign bus.result          = r_result;
  assign bus.converged       = r_conv;
  assign bus.match_hit       = r_hit;
  assign bus.match_idx       = r_midx;
endmodule

// File: tb/tb_hopfield_learn_sequencer.sv
// Purpose: self-checking bench for hopfield_learn_sequencer. Latencies are
//   counted in rising edges from the edge that accepts a start to the edge
//   that first samples the completion pulse.
module tb_hopfield_learn_sequencer;
  localparam int NP = 4;
  localparam int LC = 8;
  localparam int EP = 4;
  localparam int SC = 4;
  localparam int MR = 64;
  localparam int PW = $clog2(NP);

  typedef struct packed {
    logic [3:0]    res;
    logic          conv;
    logic          hit;
    logic [PW-1:0] idx;
    logic [7:0]    lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [3:0]    m_pat [NP];
  logic [NP-1:0] m_valid;
  exp_t          sb [$];

  always #5 clk = ~clk;

  hopfield_learn_sequencer_if #(.NUM_PATTERNS(NP)) bus ();

  hopfield_learn_sequencer #(
    .NUM_PATTERNS(NP), .LEARN_CYCLES(LC), .EPOCHS(EP),
    .STABLE_CYCLES(SC), .MAX_RECALL(MR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW:0] exp_match(input logic [3:0] v);
    logic [PW:0] r;
    r = '0;
    for (int i = NP - 1; i >= 0; i--)
      if (m_valid[i] && (m_pat[i] == v)) r = {1'b1, PW'(i)};
    return r;
  endfunction

  task automatic write_slot(input int a, input logic [3:0] d, input bit clr);
    @(negedge clk);
    bus.pat_wr_en = 1'b1; bus.pat_wr_addr = PW'(a); bus.pat_wr_data = d; bus.pat_clr = clr;
    @(negedge clk);
    bus.pat_wr_en = 1'b0; bus.pat_clr = 1'b0;
    if (clr) m_valid = '0;
    m_pat[a] = d;
    m_valid[a] = 1'b1;
  endtask

  task automatic clear_all();
    @(negedge clk); bus.pat_clr = 1'b1;
    @(negedge clk); bus.pat_clr = 1'b0;
    m_valid = '0;
  endtask

  // Builds the per-cycle learning_enable/pattern_input expectation from the
  // bench's own pattern store, then follows the DUT until train_done.
  task automatic run_train(input bit also_recall, input bit poke_write);
    logic [4:0] q [$];
    logic [4:0] e;
    int n, n_td, v;
    v = $countones(m_valid);
    for (int ep = 0; ep < EP; ep++)
      for (int s = 0; s < NP; s++)
        if (m_valid[s]) begin
          for (int c = 0; c < LC; c++) q.push_back({1'b1, m_pat[s]});
          q.push_back(5'd0);
        end
    @(negedge clk); bus.train_start = 1'b1; bus.recall_start = also_recall;
    @(negedge clk); bus.train_start = 1'b0; bus.recall_start = 1'b0;
    n = 0; n_td = -1;
    while (n_td < 0 && n < 400) begin
      if (q.size() > 0) begin
        e = q.pop_front();
        check("train_le", bus.learning_enable, e[4]);
        check("train_pi", bus.pattern_input, e[3:0]);
        check("train_busy", bus.busy, 1);
      end
      if (bus.train_done) n_td = n;
      else begin
        if (poke_write && n == 3) begin
          bus.pat_wr_en = 1'b1; bus.pat_wr_addr = '0; bus.pat_wr_data = 4'b0000;
        end
        if (n == 4) bus.pat_wr_en = 1'b0;
        @(negedge clk);
        n++;
      end
    end
    bus.pat_wr_en = 1'b0;
    check("train_done_lat", n_td + 1, (LC + 1) * v * EP + 1);
    check("train_done_busy", bus.busy, 0);
    check("train_done_le", bus.learning_enable, 0);
    @(negedge clk);
    check("train_done_pulse", bus.train_done, 0);
  endtask

  // Constant spikes 'a', or alternating a/b every cycle starting with 'a'
  // on the accepting edge.
  task automatic run_recall(input logic [3:0] pr, input bit tog,
                            input logic [3:0] a, input logic [3:0] b);
    exp_t e, g;
    logic [PW:0] m;
    int n;
    bit found;
    e.res  = tog ? ((((MR - 1) % 2) != 0) ? b : a) : a;
    e.conv = !tog;
    m      = exp_match(e.res);
    e.hit  = m[PW];
    e.idx  = m[PW-1:0];
    e.lat  = tog ? 8'(MR) : 8'(SC + 1);
    sb.push_back(e);
    @(negedge clk);
    bus.spikes = {3'($urandom_range(7)), a}; bus.probe = pr; bus.recall_start = 1'b1;
    @(negedge clk);
    bus.recall_start = 1'b0;
    check("recall_pi", bus.pattern_input, pr);
    check("recall_le", bus.learning_enable, 0);
    check("recall_busy", bus.busy, 1);
    if (tog) bus.spikes[3:0] = b;
    n = 0; found = 1'b0;
    while (!found && n < MR + 16) begin
      if (bus.result_valid) found = 1'b1;
      else begin
        @(negedge clk);
        n++;
        if (tog) bus.spikes[3:0] = (bus.spikes[3:0] == a) ? b : a;
      end
    end
    g = sb.pop_front();
    check("recall_seen", found, 1);
    check("recall_lat", n + 1, g.lat);
    check("recall_result", bus.result, g.res);
    check("recall_conv", bus.converged, g.conv);
    check("recall_hit", bus.match_hit, g.hit);
    check("recall_idx", bus.match_idx, g.idx);
    @(negedge clk);
    check("recall_rv_pulse", bus.result_valid, 0);
    check("recall_hold", bus.result, g.res);
    check("recall_idle", bus.busy, 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.pat_wr_en = 1'b0; bus.pat_wr_addr = '0; bus.pat_wr_data = '0; bus.pat_clr = 1'b0;
    bus.train_start = 1'b0; bus.recall_start = 1'b0; bus.probe = '0; bus.spikes = '0;
    m_valid = '0;
    for (int i = 0; i < NP; i++) m_pat[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_le", bus.learning_enable, 0);
    check("rst_pi", bus.pattern_input, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_td", bus.train_done, 0);
    check("rst_rv", bus.result_valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_conv", bus.converged, 0);
    check("rst_hit", bus.match_hit, 0);
    check("rst_idx", bus.match_idx, 0);
    reset = 1'b0;

    // No valid slots: immediate train_done, never busy
    run_train(1'b0, 1'b0);

    // Reset in the middle of a training run
    write_slot(0, 4'b1010, 1'b0);
    @(negedge clk); bus.train_start = 1'b1;
    @(negedge clk); bus.train_start = 1'b0;
    repeat (3) @(negedge clk);
    check("midtrain_le", bus.learning_enable, 1);
    check("midtrain_busy", bus.busy, 1);
    reset = 1'b1;
    #1;
    check("midrst_le", bus.learning_enable, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_td", bus.train_done, 0);
    @(negedge clk);
    reset = 1'b0;
    m_valid = '0;
    @(negedge clk);
    check("postrst_td", bus.train_done, 0);
    run_train(1'b0, 1'b0);

    // Clear+write in one cycle leaves only the written slot valid
    write_slot(1, 4'b1111, 1'b0);
    write_slot(3, 4'b0011, 1'b0);
    write_slot(0, 4'b1010, 1'b1);
    write_slot(2, 4'b0101, 1'b0);

    // Train with recall_start also high, and a write attempted while busy
    run_train(1'b1, 1'b1);

    run_recall(4'b1000, 1'b0, 4'b1010, 4'b0000);
    run_recall(4'b0001, 1'b0, 4'b0101, 4'b0000);
    run_recall(4'b0110, 1'b1, 4'b1111, 4'b0011);
    run_recall(4'b0100, 1'b1, 4'b1111, 4'b0101);
    run_recall(4'b1111, 1'b0, 4'b1111, 4'b0000);

    clear_all();
    run_recall(4'b1000, 1'b0, 4'b1010, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
